// File: rtl/fnv_map_engine_pkg.sv
// fnv_map_pkg: shared definitions for the FNV map engine.
//   FNV_PRIME            32-bit FNV prime
//   CMD_ADDR_W/CMD_LEN_W widths of the command fields (engine ADDR_W/LEN_W default to these)
//   fnv_state_e          engine FSM states
//   fnv_cmd_t            command / working-set bundle
//   fnv1, fnv1a          single-word FNV mixing functions (32-bit, mod 2^32)
package fnv_map_pkg;

    localparam logic [31:0] FNV_PRIME = 32'h01000193;

    localparam int unsigned CMD_ADDR_W = 8;
    localparam int unsigned CMD_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CALC,
        FINISH
    } fnv_state_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] origin;
        logic [CMD_ADDR_W-1:0] modifier;
        logic [CMD_LEN_W-1:0]  length;
        logic                  mode;
    } fnv_cmd_t;

    function automatic logic [31:0] fnv1(input logic [31:0] a, input logic [31:0] b);
        return (a * FNV_PRIME) ^ b;
    endfunction

    function automatic logic [31:0] fnv1a(input logic [31:0] a, input logic [31:0] b);
        return (a ^ b) * FNV_PRIME;
    endfunction

endpackage

// File: rtl/fnv_map_engine_lane_alu.sv
// fnv_lane_alu: one-lane combinational FNV mixer.
//   a, b  operands (a = origin word, b = modifier word)
//   mode  0 = FNV1, 1 = FNV1a (only honoured when FNV_MAP_FNV1A_EN is defined)
//   y     result
// Configuration macro: FNV_MAP_FNV1A_EN (undefined -> FNV1 only, no FNV1a datapath).
module fnv_lane_alu
    import fnv_map_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] y
);

`ifdef FNV_MAP_FNV1A_EN
    always_comb begin
        y = mode ? fnv1a(a, b) : fnv1(a, b);
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        y = fnv1(a, b);
    end
`endif

endmodule

// File: rtl/fnv_map_engine.sv
// fnv_map_engine: sequential multi-lane FNV map over an external state RAM.
//   For i in 0..length-1: state[origin+i] = fnv(state[origin+i], state[modifier+i]).
//   Command side : cmd_valid/cmd_ready handshake with origin, modifier, length,
//                  cond_pass (0 = skip) and mode (FNV1/FNV1a).
//   RAM side     : rd_en/rd_addr_a/rd_addr_b, rd_data_a/b one cycle later
//                  (LANES words, lane 0 in LSBs); wr_en/wr_addr/wr_data/wr_mask.
//   Status       : busy while a command runs, done pulses for one cycle.
// Configuration macro: FNV_MAP_FNV1A_EN (defined -> cmd_mode selects FNV1a).
module fnv_map_engine
    import fnv_map_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = CMD_ADDR_W,
    parameter int unsigned LEN_W  = CMD_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_origin,
    input  logic [ADDR_W-1:0]       cmd_modifier,
    input  logic [LEN_W-1:0]        cmd_length,
    input  logic                    cmd_cond_pass,
    input  logic                    cmd_mode,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr_a,
    output logic [ADDR_W-1:0]       rd_addr_b,
    input  logic [LANES*WORD_W-1:0] rd_data_a,
    input  logic [LANES*WORD_W-1:0] rd_data_b,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LANES*WORD_W-1:0] wr_data,
    output logic [LANES-1:0]        wr_mask,
    output logic                    busy,
    output logic                    done
);

    fnv_state_e state;
    // Working set: origin/modifier advance per chunk, length counts remaining words.
    fnv_cmd_t   cur;
    logic       single_q;

    logic [ADDR_W-1:0]       alias_diff;
    logic                    alias_single;
    logic [31:0]             step;
    logic [31:0]             chunk_cnt;
    logic [LANES-1:0]        lane_mask;
    logic [LANES*WORD_W-1:0] alu_y;
    logic                    acc_mode;

`ifdef FNV_MAP_FNV1A_EN
    assign acc_mode = cmd_mode;
`else
    logic unused_cmd_mode;
    assign unused_cmd_mode = cmd_mode;
    assign acc_mode        = 1'b0;
`endif

    // An origin range starting 1..LANES-1 words above the modifier range would
    // read words that an earlier lane of the same chunk is about to overwrite;
    // those commands run one word per chunk to keep sequential semantics.
    always_comb begin
        alias_diff   = cmd_origin - cmd_modifier;
        alias_single = (alias_diff != '0) && (32'(alias_diff) < LANES);
    end

    always_comb begin
        step      = single_q ? 32'd1 : 32'(LANES);
        chunk_cnt = (32'(cur.length) < step) ? 32'(cur.length) : step;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_mask[j] = (j < chunk_cnt);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fnv_lane_alu u_alu (
            .a    (rd_data_a[g*WORD_W +: WORD_W]),
            .b    (rd_data_b[g*WORD_W +: WORD_W]),
            .mode (cur.mode),
            .y    (alu_y[g*WORD_W +: WORD_W])
        );
    end

    always_comb begin
        wr_data = wr_en ? alu_y : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            single_q  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_mask   <= '0;
        end else begin
            done    <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            wr_mask <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur <= '{origin:   cmd_origin,
                                 modifier: cmd_modifier,
                                 length:   cmd_length,
                                 mode:     acc_mode};
                        single_q  <= alias_single;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (!cmd_cond_pass || cmd_length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            rd_en     <= 1'b1;
                            rd_addr_a <= cmd_origin;
                            rd_addr_b <= cmd_modifier;
                        end
                    end
                end
                READ: begin
                    state   <= CALC;
                    wr_en   <= 1'b1;
                    wr_addr <= cur.origin;
                    wr_mask <= lane_mask;
                end
                CALC: begin
                    cur.origin   <= cur.origin + ADDR_W'(step);
                    cur.modifier <= cur.modifier + ADDR_W'(step);
                    cur.length   <= cur.length - LEN_W'(chunk_cnt);
                    if (32'(cur.length) == chunk_cnt) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state     <= READ;
                        rd_en     <= 1'b1;
                        rd_addr_a <= cur.origin + ADDR_W'(step);
                        rd_addr_b <= cur.modifier + ADDR_W'(step);
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnv_map_engine.sv
// Self-checking bench for fnv_map_engine: behavioural state RAM, reference
// model of sequential FNV evaluation, write scoreboard and cycle checks.
module tb_fnv_map_engine;

    localparam int LANES  = 4;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_W-1:0]       cmd_origin;
    logic [ADDR_W-1:0]       cmd_modifier;
    logic [LEN_W-1:0]        cmd_length;
    logic                    cmd_cond_pass;
    logic                    cmd_mode;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr_a;
    logic [ADDR_W-1:0]       rd_addr_b;
    logic [LANES*WORD_W-1:0] rd_data_a;
    logic [LANES*WORD_W-1:0] rd_data_b;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LANES*WORD_W-1:0] wr_data;
    logic [LANES-1:0]        wr_mask;
    logic                    busy;
    logic                    done;

    fnv_map_engine #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier), .cmd_length(cmd_length),
        .cmd_cond_pass(cmd_cond_pass), .cmd_mode(cmd_mode),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
    } wr_exp_t;

    wr_exp_t     sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          rd_count = 0;
    logic [31:0] mem [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fnv(input logic [31:0] a, input logic [31:0] b, input logic md);
        logic [63:0] p;
        if (md) begin
            p = {32'd0, a ^ b} * 64'h0000_0000_0100_0193;
            return p[31:0];
        end
        p = {32'd0, a} * 64'h0000_0000_0100_0193;
        return p[31:0] ^ b;
    endfunction

    // State RAM: reads return one cycle after rd_en, writes land at the clock edge.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int j = 0; j < LANES; j++) begin
                rd_data_a[j*32 +: 32] <= mem[8'(int'(rd_addr_a) + j)];
                rd_data_b[j*32 +: 32] <= mem[8'(int'(rd_addr_b) + j)];
            end
        end
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                if (wr_mask[j]) mem[8'(int'(wr_addr) + j)] = wr_data[j*32 +: 32];
            end
        end
    end

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rd_en) rd_count++;
        if (wr_en) begin
            check("write_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                wr_exp_t e;
                logic [127:0] lm;
                e  = sb.pop_front();
                lm = '0;
                for (int j = 0; j < LANES; j++) if (e.mask[j]) lm[j*32 +: 32] = '1;
                check("wr_addr", 128'(wr_addr), 128'(e.addr));
                check("wr_mask", 128'(wr_mask), 128'(e.mask));
                check("wr_data", wr_data & lm, e.data);
            end
        end
    end

    // Pushes the expected writes of a command; returns chunk count.
    task automatic expect_cmd(input logic [7:0] o, input logic [7:0] m, input logic [7:0] len,
                              input logic cond, input logic mode, output int n_chunks);
        logic [31:0] refm [256];
        logic [7:0]  d;
        logic        md;
        int          step;
        refm = mem;
        d    = o - m;
        step = (d != 0 && int'(d) < LANES) ? 1 : LANES;
`ifdef FNV_MAP_FNV1A_EN
        md = mode;
`else
        md = 1'b0;
        if (mode) md = 1'b0;
`endif
        n_chunks = 0;
        if (cond && len != 0) begin
            for (int i = 0; i < int'(len); i++)
                refm[8'(int'(o) + i)] = ref_fnv(refm[8'(int'(o) + i)], refm[8'(int'(m) + i)], md);
            n_chunks = (int'(len) + step - 1) / step;
            for (int k = 0; k < n_chunks; k++) begin
                wr_exp_t e;
                int cnt;
                cnt    = int'(len) - k * step;
                if (cnt > step) cnt = step;
                e.addr = 8'(int'(o) + k * step);
                e.mask = '0;
                e.data = '0;
                for (int j = 0; j < cnt; j++) begin
                    e.mask[j]          = 1'b1;
                    e.data[j*32 +: 32] = refm[8'(int'(e.addr) + j)];
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_cmd(input logic [7:0] o, input logic [7:0] m, input logic [7:0] len,
                             input logic cond, input logic mode);
        cmd_valid     = 1'b1;
        cmd_origin    = o;
        cmd_modifier  = m;
        cmd_length    = len;
        cmd_cond_pass = cond;
        cmd_mode      = mode;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] o, input logic [7:0] m, input logic [7:0] len,
                           input logic cond, input logic mode, input string tag);
        int n_chunks, exp_done, got, rd0;
        for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
        check({tag, "_ready_before"}, 128'(cmd_ready), 128'(1));
        expect_cmd(o, m, len, cond, mode, n_chunks);
        exp_done = (n_chunks == 0) ? 1 : 2 * n_chunks + 1;
        rd0      = rd_count;
        got      = 0;
        drive_cmd(o, m, len, cond, mode);
        for (int c = 1; c <= exp_done + 6; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, "_busy_ready_c1"}, 128'({busy, cmd_ready}), 128'(2'b10));
            if (done) begin
                got = c;
                break;
            end
        end
        check({tag, "_done_cycle"}, 128'(got), 128'(exp_done));
        @(negedge clk);
        check({tag, "_after_done"}, 128'({cmd_ready, done, busy}), 128'(3'b100));
        check({tag, "_reads"}, 128'(rd_count - rd0), 128'(n_chunks));
        check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int          n, seen_done;
        logic [31:0] saved;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rd_data_a     = '0;
        rd_data_b     = '0;
        cmd_valid     = 1'b0;
        cmd_origin    = '0;
        cmd_modifier  = '0;
        cmd_length    = '0;
        cmd_cond_pass = 1'b0;
        cmd_mode      = 1'b0;
        rst           = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_during", 128'({cmd_ready, busy, done, rd_en, wr_en, wr_mask, wr_data}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 128'b0}) | (128'(1) << 135 >> 8));
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 128'(cmd_ready), 128'(1));
        check("reset_outs", 128'({busy, done, rd_en, wr_en, wr_mask, rd_addr_a, rd_addr_b, wr_addr}), 128'(0));

        // Basic four-word chunk.
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 32'(i + 1);
            mem[i + 4] = 32'd0;
        end
        run_cmd(8'h00, 8'h04, 8'd4, 1'b1, 1'b0, "basic");
        check("basic_mem", {mem[3], mem[2], mem[1], mem[0]},
              128'h0400064C_030004B9_02000326_01000193);

        // Backward alias forces single-lane chunks.
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        run_cmd(8'h01, 8'h00, 8'd3, 1'b1, 1'b0, "alias");
        check("alias_mem", {32'd0, mem[3], mem[2], mem[1]},
              {32'd0, 32'h050001D2, 32'h0100079E, 32'h02000327});

        // Tail chunk, same-base and forward overlap.
        run_cmd(8'h10, 8'h20, 8'd6, 1'b1, 1'b0, "tail");
        run_cmd(8'h30, 8'h30, 8'd5, 1'b1, 1'b0, "same_base");
        run_cmd(8'h40, 8'h42, 8'd7, 1'b1, 1'b0, "fwd_overlap");

        // Skipped commands.
        run_cmd(8'h50, 8'h60, 8'd4, 1'b0, 1'b0, "skip_cond");
        run_cmd(8'h50, 8'h60, 8'd0, 1'b1, 1'b0, "skip_len0");

        // Mode selection.
        mem[8'h80] = 32'd2;
        mem[8'h81] = 32'd3;
        run_cmd(8'h80, 8'h81, 8'd1, 1'b1, 1'b1, "mode");
`ifdef FNV_MAP_FNV1A_EN
        check("mode_result", 128'(mem[8'h80]), 128'h01000193);
`else
        check("mode_result", 128'(mem[8'h80]), 128'h02000325);
`endif

        // Address wrap with reset in cycle 3.
        for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
        saved = mem[8'h02];
        expect_cmd(8'hFE, 8'h40, 8'd8, 1'b1, 1'b0, n);
        while (sb.size() > 1) void'(sb.pop_back());
        drive_cmd(8'hFE, 8'h40, 8'd8, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wrap_first_write", 128'({wr_en, wr_addr}), 128'({1'b1, 8'hFE}));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("wrap_second_read", 128'({rd_en, rd_addr_a}), 128'({1'b1, 8'h02}));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 128'(cmd_ready), 128'(1));
        check("abort_outs", 128'({busy, done, rd_en, wr_en, wr_mask, wr_data}), 128'(0));
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", 128'(seen_done), 128'(0));
        check("abort_sb_empty", 128'(sb.size()), 128'(0));
        check("abort_mem_untouched", 128'(mem[8'h02]), 128'(saved));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fnv_map_engine.md
Name: fnv_map_engine

Overview:
- Sequential, multi-lane successor to the combinational FNV map primitive.
- For i in 0..length-1 it computes state[origin+i] = fnv(state[origin+i], state[modifier+i]) over an external word-addressed state memory.
- Processes up to LANES words per chunk and falls back to one lane when the address ranges alias.
- Sits between the instruction sequencer (command handshake) and the execution-environment state RAM (read/write ports).

Parameters:
- LANES, 4, words processed per chunk; power of two, ≥1.
- WORD_W, 32, word width; FNV arithmetic is always 32-bit, so WORD_W must equal 32.
- ADDR_W, 8, state word address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 8, width of the length field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd_origin  in  ADDR_W  destination / first-operand base.
- cmd_modifier  in  ADDR_W  second-operand base.
- cmd_length  in  LEN_W  word count.
- cmd_cond_pass  in  1  upstream conditional-flag result; 0 = skip.
- cmd_mode  in  1  0 = FNV1, 1 = FNV1a (see Optional Feature).
- rd_en  out  1  read request.
- rd_addr_a  out  ADDR_W  origin chunk base.
- rd_addr_b  out  ADDR_W  modifier chunk base.
- rd_data_a  in  LANES*WORD_W  words addr_a..addr_a+LANES-1; valid 1 cycle after rd_en; lane 0 in LSBs.
- rd_data_b  in  LANES*WORD_W  same, for rd_addr_b.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write chunk base.
- wr_data  out  LANES*WORD_W  results.
- wr_mask  out  LANES  per-lane write enable.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous, active-high on rst.
  - Every output except cmd_ready is 0 during and after reset; cmd_ready is 1 after reset.
  - FSM returns to IDLE.
  - rst mid-operation aborts the command; no further writes are issued and no done pulse is produced.
- FSM states: IDLE, READ, CALC, FINISH.
- IDLE:
  - cmd_ready = 1.
  - Accept on cmd_valid & cmd_ready; latch origin, modifier, length and mode.
  - Compute eff_lanes = 1 if 0 < (origin - modifier) mod 2^ADDR_W < LANES, else LANES.
  - If cond_pass = 0 or length = 0, go to FINISH; otherwise go to READ.
- READ:
  - rd_en = 1, rd_addr_a = cur_origin, rd_addr_b = cur_modifier.
  - Next state is CALC.
- CALC:
  - rd_data is valid; compute each lane combinationally.
    - FNV1: (a*0x01000193) ^ b, mod 2^32.
    - FNV1a: (a^b)*0x01000193, mod 2^32.
  - wr_en = 1, wr_addr = cur_origin.
  - wr_mask lane j = 1 when j < min(eff_lanes, remaining).
  - Advance cur_origin and cur_modifier by eff_lanes (wrap); decrement remaining.
  - If remaining = 0, go to FINISH; otherwise go to READ.
- FINISH: done = 1 for one cycle, then IDLE.
- busy = 1 in READ, CALC and FINISH.
- Timing: the accept cycle is cycle 0 and a command has N chunks.
  - Chunk k: READ at cycle 2k+1, CALC/write at cycle 2k+2.
  - done at cycle 2N+1.
  - Skipped command: done at cycle 1, no rd_en, no wr_en.
- Result semantics are identical to sequential i = 0..length-1 evaluation.
  - origin == modifier is safe.
  - A modifier range above origin is safe, because all reads of a chunk precede its writes.
  - The single-lane fallback covers backward aliasing.
- A cmd_valid arriving while busy is held off (cmd_ready = 0); no command is dropped.

Optional Feature:
- Macro: FNV_MAP_FNV1A_EN.
- Defined: cmd_mode is latched per command and selects FNV1 or FNV1a.
- Undefined:
  - cmd_mode is ignored and FNV1 is always used.
  - No FNV1a multiplier-path logic is synthesised.
  - The port remains present for interface stability.

Decomposition:
- Package fnv_map_pkg holds:
  - FNV_PRIME = 32'h01000193.
  - fnv1 and fnv1a functions.
  - fnv_state_e enum (IDLE, READ, CALC, FINISH).
  - fnv_cmd_t packed struct (origin, modifier, length, mode).
- Sub-module fnv_lane_alu: one-lane combinational FNV1/FNV1a, instantiated LANES times in a generate loop.
- The FSM, counters and alias check live in fnv_map_engine.

Test Plan:
- LANES=4, length=4, origin=0, modifier=4, mem[0..3]=1,2,3,4, mem[4..7]=0 → single write with mask 4'b1111; data 0x01000193, 0x02000326, 0x030004B9, 0x0400064C; done at cycle 3.
- Backward alias: origin=1, modifier=0, length=3, mem[0..3]=1,2,3,4 → single-lane mode; mem[1..3]=0x02000327, 0x0100079E, 0x050001D2; done at cycle 7.
- Tail: length=6, origin=0x10, modifier=0x20 → two writes at 0x10 and 0x14; second wr_mask=4'b0011; done at cycle 5.
- Skip: cmd_cond_pass=0 (and separately length=0) → no rd_en or wr_en; done at cycle 1; cmd_ready high again at cycle 2.
- Wrap and reset: origin=0xFE, length=8, rst asserted in cycle 3 → after the first write at 0xFE, no further wr_en; outputs 0; cmd_ready=1 the cycle after rst.
- With FNV_MAP_FNV1A_EN and cmd_mode=1: a=2, b=3 → result 0x01000193; without the macro the same stimulus gives 0x02000325.
